// File: rtl/gen_sequencer.sv
// Generation sequencer: steps a row grid through LOAD -> COMPUTE -> WRITEBACK per generation.
// Optional macro GEN_SEQ_GEN_COUNTER_EN adds the completed-generation counter; otherwise generation reads 0.
module gen_sequencer #(
  parameter int ROWS           = 8,
  parameter int ADDR_W         = 3,
  parameter int COMPUTE_CYCLES = 2,
  parameter int GEN_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic              mem_ready,
  output logic [1:0]        phase,
  output logic [ADDR_W-1:0] row_addr,
  output logic              row_strobe,
  output logic              busy,
  output logic              gen_done,
  output logic [GEN_W-1:0]  generation
);

  typedef enum logic [1:0] {
    PH_IDLE      = 2'b00,
    PH_LOAD      = 2'b01,
    PH_COMPUTE   = 2'b10,
    PH_WRITEBACK = 2'b11
  } phase_e;

  localparam int                CNT_W    = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(COMPUTE_CYCLES - 1);

  phase_e              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic                run_q, run_d;
  logic                stop_q, stop_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                wb_last;

  assign wb_last = (state_q == PH_WRITEBACK) && mem_ready && (row_q == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_IDLE;
      row_q   <= '0;
      run_q   <= 1'b0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      run_q   <= run_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      PH_IDLE: begin
        if (start) begin
          state_d = PH_LOAD;
          row_d   = '0;
          run_d   = continuous;
        end
      end
      PH_LOAD: begin
        if (mem_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = PH_COMPUTE;
            row_d   = '0;
            cnt_d   = CNT_LOAD;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      PH_COMPUTE: begin
        // Counter holds the remaining dwell minus one; zero means this is the last cycle.
        row_d = '0;
        if (cnt_q == '0) begin
          state_d = PH_WRITEBACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PH_WRITEBACK: begin
        if (wb_last) begin
          done_d  = 1'b1;
          row_d   = '0;
          state_d = (run_q && !stop_q && !stop) ? PH_LOAD : PH_IDLE;
        end else if (mem_ready) begin
          row_d = row_q + 1'b1;
        end
      end
      default: begin
        state_d = PH_IDLE;
        row_d   = '0;
      end
    endcase
    // Stop request is sticky until the block lands in IDLE.
    stop_d = (state_d == PH_IDLE) ? 1'b0 : (stop_q | stop);
  end

  always_comb begin
    phase      = state_q;
    row_addr   = row_q;
    row_strobe = (state_q == PH_LOAD) || (state_q == PH_WRITEBACK);
    busy       = (state_q != PH_IDLE);
    gen_done   = done_q;
  end

`ifdef GEN_SEQ_GEN_COUNTER_EN
  logic [GEN_W-1:0] gen_q, gen_d;

  assign gen_d = wb_last ? gen_q + 1'b1 : gen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_q <= '0;
    end else begin
      gen_q <= gen_d;
    end
  end

  assign generation = gen_q;
`else
  assign generation = '0;
`endif

endmodule
